// File: rtl/if_id_stage_if.sv
// Signal bundle between the IF stage, EX hazard feedback and the IF/ID pipeline register.
// The slave side is the IF/ID stage itself; the master side drives fetch and hazard inputs.
interface if_id_stage_if;
  logic [31:0] pc_if;
  logic [31:0] inst_if;
  logic        flush;
  logic        ext_stall;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic [31:0] pc_id;
  logic [31:0] pc4_id;
  logic [31:0] inst_id;
  logic        valid_id;
  logic        stall_out;
  logic        bubble_id;
  logic [31:0] stall_cnt;

  modport master (
    output pc_if, inst_if, flush, ext_stall, idex_mem_read, idex_rd,
    input  pc_id, pc4_id, inst_id, valid_id, stall_out, bubble_id, stall_cnt
  );

  modport slave (
    input  pc_if, inst_if, flush, ext_stall, idex_mem_read, idex_rd,
    output pc_id, pc4_id, inst_id, valid_id, stall_out, bubble_id, stall_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection and a saturating stall counter.
// Capture priority is flush > hold > normal; stall_out and bubble_id are combinational.
module if_id_stage (
  input logic          clk,
  input logic          rst_n,
  if_id_stage_if.slave bus
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0] pc_r;
  logic [31:0] pc4_r;
  logic [31:0] inst_r;
  logic        valid_r;
  logic [31:0] cnt_r;

  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [6:0]  opcode_s;
  logic        rs1_used_s;
  logic        rs2_used_s;
  logic        load_use_s;
  logic        hold_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  // Decode source-register usage of the instruction sitting in ID.
  always_comb begin
    rs1_s      = inst_r[19:15];
    rs2_s      = inst_r[24:20];
    opcode_s   = inst_r[6:0];
    rs1_used_s = 1'b0;
    rs2_used_s = 1'b0;
    case (opcode_s)
      7'b1100111, 7'b0000011, 7'b0010011: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
      end
      7'b1100011, 7'b0100011, 7'b0110011: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
      end
      default: begin
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
      end
    endcase
  end

  // Load-use hazard against the load in EX; x0 as destination never hazards.
  always_comb begin
    load_use_s = valid_r & bus.idex_mem_read & (bus.idex_rd != 5'd0) &
                 ((rs1_used_s & (rs1_s == bus.idex_rd)) |
                  (rs2_used_s & (rs2_s == bus.idex_rd)));
    hold_s     = load_use_s | bus.ext_stall;
  end

  // Pipeline register: flush squashes to a NOP even if a hold is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RESET_PC;
      pc4_r   <= RESET_PC + 32'd4;
      inst_r  <= NOP_INST;
      valid_r <= 1'b0;
    end else if (bus.flush) begin
      pc_r    <= bus.pc_if;
      pc4_r   <= bus.pc_if + 32'd4;
      inst_r  <= NOP_INST;
      valid_r <= 1'b0;
    end else if (hold_s) begin
      pc_r    <= pc_r;
      pc4_r   <= pc4_r;
      inst_r  <= inst_r;
      valid_r <= valid_r;
    end else begin
      pc_r    <= bus.pc_if;
      pc4_r   <= bus.pc_if + 32'd4;
      inst_r  <= bus.inst_if;
      valid_r <= 1'b1;
    end
  end

  // Count load-use stall cycles that actually take effect; ext_stall alone never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 32'd0;
    end else if (load_use_s & ~bus.flush) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.pc_id     = pc_r;
  assign bus.pc4_id    = pc4_r;
  assign bus.inst_id   = inst_r;
  assign bus.valid_id  = valid_r;
  assign bus.stall_cnt = cnt_r;
  assign bus.stall_out = hold_s & ~bus.flush;
  assign bus.bubble_id = load_use_s | ~valid_r | bus.flush;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: a reference model predicts the post-edge state,
// pushes it to a queue, and each scenario pops and compares after the edge.
module tb_if_id_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] cnt;
  } state_t;

  localparam logic [31:0] ADD_X6 = 32'h0072_8333;
  localparam logic [31:0] LUI_X5 = 32'h0000_52B7;
  localparam logic [31:0] ADDI_1 = 32'h0050_0093;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  state_t exp_q[$];
  state_t m;
  state_t e;
  int     vectors     = 0;
  int     miscompares = 0;

  function automatic state_t bus_state();
    bus_state = {bus.pc_id, bus.pc4_id, bus.inst_id, bus.valid_id, bus.stall_cnt};
  endfunction

  function automatic logic m_load_use();
    logic [6:0] op;
    logic       u1;
    logic       u2;
    op = m.inst[6:0];
    u1 = op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    u2 = op inside {7'b1100011, 7'b0100011, 7'b0110011};
    m_load_use = m.valid && bus.idex_mem_read && (bus.idex_rd != 5'd0) &&
                 ((u1 && (m.inst[19:15] == bus.idex_rd)) || (u2 && (m.inst[24:20] == bus.idex_rd)));
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic fl,
                       input logic xs, input logic mr, input logic [4:0] rd);
    bus.pc_if         = pc;
    bus.inst_if       = inst;
    bus.flush         = fl;
    bus.ext_stall     = xs;
    bus.idex_mem_read = mr;
    bus.idex_rd       = rd;
  endtask

  // Predict the next state from the present inputs, queue it, then advance one edge.
  task automatic edge_q();
    logic lu;
    lu = m_load_use();
    if (lu && !bus.flush && (m.cnt != 32'hFFFF_FFFF)) m.cnt = m.cnt + 32'd1;
    if (bus.flush) begin
      m.pc = bus.pc_if; m.pc4 = bus.pc_if + 32'd4; m.inst = NOP; m.valid = 1'b0;
    end else if (!(lu || bus.ext_stall)) begin
      m.pc = bus.pc_if; m.pc4 = bus.pc_if + 32'd4; m.inst = bus.inst_if; m.valid = 1'b1;
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(32'h0000_1000, ADDI_1, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m = '{pc: 32'h0000_3000, pc4: 32'h0000_3004, inst: NOP, valid: 1'b0, cnt: 32'd0};
    vectors++;
    if (bus_state() !== m) begin
      miscompares++; $display("FAIL reset_async got %p want %p", bus_state(), m);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(32'h0000_3000, ADDI_1, 1'b0, 1'b0, 1'b1, 5'd1);
    #1;
    vectors++;
    if ({bus.stall_out, bus.bubble_id} !== 2'b01) begin
      miscompares++; $display("FAIL reset_comb got %b want %b", {bus.stall_out, bus.bubble_id}, 2'b01);
    end
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL reset_first_capture got %p want %p", bus_state(), e);
    end
    vectors++;
    if ({bus.pc_id, bus.pc4_id, bus.valid_id} !== {32'h0000_3000, 32'h0000_3004, 1'b1}) begin
      miscompares++; $display("FAIL reset_first_pc got %h/%h/%b want 3000/3004/1", bus.pc_id, bus.pc4_id, bus.valid_id);
    end
  endtask

  task automatic test_load_use();
    drive(32'h0000_3004, ADD_X6, 1'b0, 1'b0, 1'b0, 5'd0);
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL lu_load_add got %p want %p", bus_state(), e);
    end
    drive(32'h0000_3008, ADD_X6, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    vectors++;
    if ({bus.stall_out, bus.bubble_id} !== 2'b11) begin
      miscompares++; $display("FAIL lu_comb got %b want %b", {bus.stall_out, bus.bubble_id}, 2'b11);
    end
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL lu_hold got %p want %p", bus_state(), e);
    end
    vectors++;
    if ({bus.pc_id, bus.stall_cnt} !== {32'h0000_3004, 32'd1}) begin
      miscompares++; $display("FAIL lu_count got pc=%h cnt=%0d want pc=3004 cnt=1", bus.pc_id, bus.stall_cnt);
    end
    bus.idex_mem_read = 1'b0;
    #1;
    vectors++;
    if (bus.stall_out !== 1'b0) begin
      miscompares++; $display("FAIL lu_release got %b want 0", bus.stall_out);
    end
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL lu_advance got %p want %p", bus_state(), e);
    end
    // Load-use together with ext_stall: still one increment per cycle.
    drive(32'h0000_300C, LUI_X5, 1'b0, 1'b1, 1'b1, 5'd7);
    for (int i = 0; i < 2; i++) begin
      edge_q();
      e = exp_q.pop_front(); vectors++;
      if (bus_state() !== e) begin
        miscompares++; $display("FAIL lu_with_ext[%0d] got %p want %p", i, bus_state(), e);
      end
    end
    vectors++;
    if (bus.stall_cnt !== 32'd3) begin
      miscompares++; $display("FAIL lu_with_ext_count got %0d want 3", bus.stall_cnt);
    end
  endtask

  task automatic test_no_hazard();
    drive(32'h0000_300C, LUI_X5, 1'b0, 1'b0, 1'b1, 5'd0);
    #1;
    vectors++;
    if (bus.stall_out !== 1'b0) begin
      miscompares++; $display("FAIL nohaz_rd0 got %b want 0", bus.stall_out);
    end
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL nohaz_load_lui got %p want %p", bus_state(), e);
    end
    drive(32'h0000_3010, ADD_X6, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    vectors++;
    if ({bus.stall_out, bus.bubble_id} !== 2'b00) begin
      miscompares++; $display("FAIL nohaz_lui got %b want %b", {bus.stall_out, bus.bubble_id}, 2'b00);
    end
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL nohaz_advance got %p want %p", bus_state(), e);
    end
  endtask

  task automatic test_flush_over_stall();
    drive(32'h0000_5000, LUI_X5, 1'b1, 1'b0, 1'b1, 5'd5);
    #1;
    vectors++;
    if ({bus.stall_out, bus.bubble_id} !== 2'b01) begin
      miscompares++; $display("FAIL flush_comb got %b want %b", {bus.stall_out, bus.bubble_id}, 2'b01);
    end
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL flush_state got %p want %p", bus_state(), e);
    end
    vectors++;
    if ({bus.inst_id, bus.valid_id, bus.stall_cnt} !== {NOP, 1'b0, 32'd3}) begin
      miscompares++; $display("FAIL flush_nop got %h/%b/%0d want 13/0/3", bus.inst_id, bus.valid_id, bus.stall_cnt);
    end
    drive(32'h0000_5004, ADD_X6, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    vectors++;
    if ({bus.stall_out, bus.bubble_id} !== 2'b01) begin
      miscompares++; $display("FAIL invalid_no_lu got %b want %b", {bus.stall_out, bus.bubble_id}, 2'b01);
    end
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL flush_resume got %p want %p", bus_state(), e);
    end
  endtask

  task automatic test_ext_stall();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_4000 + 32'(i * 4), LUI_X5, 1'b0, 1'b1, 1'b0, 5'd0);
      #1;
      vectors++;
      if (bus.stall_out !== 1'b1) begin
        miscompares++; $display("FAIL ext_comb[%0d] got %b want 1", i, bus.stall_out);
      end
      edge_q();
      e = exp_q.pop_front(); vectors++;
      if (bus_state() !== e) begin
        miscompares++; $display("FAIL ext_hold[%0d] got %p want %p", i, bus_state(), e);
      end
    end
    drive(32'h0000_400C, LUI_X5, 1'b0, 1'b0, 1'b0, 5'd0);
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL ext_resume got %p want %p", bus_state(), e);
    end
    vectors++;
    if ({bus.pc_id, bus.stall_cnt} !== {32'h0000_400C, 32'd3}) begin
      miscompares++; $display("FAIL ext_resume_pc got pc=%h cnt=%0d want 400c/3", bus.pc_id, bus.stall_cnt);
    end
  endtask

  task automatic test_pc_wrap();
    drive(32'hFFFF_FFFC, ADD_X6, 1'b0, 1'b0, 1'b0, 5'd0);
    edge_q();
    e = exp_q.pop_front(); vectors++;
    if (bus_state() !== e) begin
      miscompares++; $display("FAIL wrap_state got %p want %p", bus_state(), e);
    end
    vectors++;
    if (bus.pc4_id !== 32'h0000_0000) begin
      miscompares++; $display("FAIL wrap_pc4 got %h want 00000000", bus.pc4_id);
    end
  endtask

  task automatic test_saturation();
    force dut.cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_r;
    m.cnt = 32'hFFFF_FFFF;
    drive(32'h0000_6000, ADD_X6, 1'b0, 1'b0, 1'b1, 5'd7);
    for (int i = 0; i < 2; i++) begin
      edge_q();
      e = exp_q.pop_front(); vectors++;
      if (bus_state() !== e) begin
        miscompares++; $display("FAIL sat_state[%0d] got %p want %p", i, bus_state(), e);
      end
    end
    vectors++;
    if (bus.stall_cnt !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL sat_count got %h want ffffffff", bus.stall_cnt);
    end
  endtask

  initial begin
    drive(32'h0, NOP, 1'b0, 1'b0, 1'b0, 5'd0);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush_over_stall();
    test_ext_stall();
    test_pc_wrap();
    test_saturation();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 pc_if  input  32  fetch PC from the IF stage PC register.
REQ-006 inst_if  input  32  instruction read combinationally from instruction memory at pc_if.
REQ-007 flush  input  1  taken branch/jump redirect from EX; squashes the ID contents.
REQ-008 ext_stall  input  1  external hold, e.g. data-memory busy.
REQ-009 idex_mem_read  input  1  instruction in EX is a load.
REQ-010 idex_rd  input  5  destination register of the instruction in EX.
REQ-011 pc_id  output  32  registered PC of the instruction in ID.
REQ-012 pc4_id  output  32  pc_id + 4.
REQ-013 inst_id  output  32  registered instruction in ID.
REQ-014 valid_id  output  1  inst_id is a live instruction.
REQ-015 stall_out  output  1  hold request, driven to the IF stage stall input.
REQ-016 bubble_id  output  1  tells ID/EX to zero its control signals this cycle.
REQ-017 stall_cnt  output  32  saturating count of load-use stall cycles.

Function
REQ-018 SHALL capture state on the rising edge with this priority: flush > hold > normal.
REQ-019 Flush: SHALL load inst_id=32'h0000_0013 (NOP) and valid_id=0; pc_id is don't-care but SHALL be loaded with pc_if.
REQ-020 Hold (load_use | ext_stall, without flush): SHALL keep pc_id, inst_id and valid_id unchanged.
REQ-021 Normal: SHALL load pc_id=pc_if, inst_id=inst_if and valid_id=1.
REQ-022 SHALL decode rs1=inst_id[19:15], rs2=inst_id[24:20] and opcode=inst_id[6:0].
REQ-023 rs1 is used for opcodes 1100111, 1100011, 0000011, 0100011, 0010011 and 0110011.
REQ-024 rs2 is used for opcodes 1100011, 0100011 and 0110011.
REQ-025 load_use SHALL equal valid_id & idex_mem_read & (idex_rd!=0) & ((rs1 used & rs1==idex_rd) | (rs2 used & rs2==idex_rd)), combinationally.
REQ-026 stall_out SHALL equal (load_use | ext_stall) & ~flush, combinationally.
REQ-027 The IF stage gives stall priority over branch, so stall_out SHALL never be asserted while flush is asserted.
REQ-028 bubble_id SHALL equal load_use | ~valid_id | flush, combinationally.
REQ-029 A load-use hazard SHALL cost exactly one stall cycle: the load advances to MEM, idex_mem_read drops, and the hold releases on the next edge.
REQ-030 ext_stall SHALL hold for as many cycles as it is asserted; it has no timeout.
REQ-031 pc4_id SHALL be pc_id + 32'd4, modulo 2^32; it wraps from 32'hFFFF_FFFC to 0.
REQ-032 stall_cnt SHALL increment by 1 on each edge where load_use & ~flush.
REQ-033 stall_cnt SHALL saturate at 32'hFFFF_FFFF and never wrap.
REQ-034 Simultaneous load_use and ext_stall SHALL still count as one increment per cycle.
REQ-035 An instruction with valid_id=0 SHALL never raise load_use, and a NOP SHALL never match because rd and rs are x0.

Reset
REQ-036 While rst_n=0: pc_id=32'h0000_3000, inst_id=32'h0000_0013, valid_id=0, stall_cnt=0, taking effect immediately without waiting for a clock edge.
REQ-037 Out of reset: stall_out=0 and bubble_id=1 until the first normal capture.
REQ-038 Reset asserted mid-stall or mid-flush SHALL discard that operation.
REQ-039 The first edge after rst_n rises SHALL perform a normal capture of pc_if/inst_if.

Verification
REQ-040 Reset check: assert rst_n=0 between clock edges -> outputs equal the REQ-036 values at once; release with pc_if=0x3000, inst_if=0x00500093 -> next edge gives pc_id=0x3000, pc4_id=0x3004, valid_id=1.
REQ-041 Load-use check: idex_mem_read=1, idex_rd=5, inst_id=add x6,x5,x7 (0x00728333) -> stall_out=1 and bubble_id=1 for one cycle, pc_id held, stall_cnt 0->1; then idex_mem_read=0 -> advance.
REQ-042 No-hazard cases: idex_rd=0 -> stall_out=0; idex_rd=5 with inst_id=lui x5 (0x000052B7, no rs use) -> stall_out=0.
REQ-043 Flush-over-stall: load-use active and flush=1 in the same cycle -> stall_out=0, next edge inst_id=0x13, valid_id=0, stall_cnt unchanged.
REQ-044 ext_stall held 3 cycles -> pc_id/inst_id stable for 3 edges, stall_cnt unchanged, then resume with the pc_if present at release.
REQ-045 Saturation: force stall_cnt=0xFFFF_FFFF, then create a load-use hazard -> stall_cnt stays 0xFFFF_FFFF.
